alu_mc: RTL and testbench

- Execute stage that consumes the 4-bit ALU control code and two 32-bit operands. Produces the registered result, status flags and HI/LO.
- Single-cycle ops complete in 1 clock. MULT/MULTU run on an iterative shift-add multiplier taking 32 iterations, with a valid/ready handshake toward the decode/issue stage.
- Sits between the register-read/immediate-select stage and the memory/writeback stage of the MIPS core.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/mul_iter.sv | 52 +++++
 rtl/alu_mc.sv | 145 ++++++++++++++
 tb/tb_alu_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_mc execute stage.
//   - WIDTH_DEFAULT / CTRL_W_DEFAULT: default datapath and control-code widths
//   - ALU_* : ALU control code encodings
//   - state_t : alu_mc FSM state encoding
package alu_pkg;

   localparam int WIDTH_DEFAULT  = 32;
   localparam int CTRL_W_DEFAULT = 4;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_ADDU  = 4'b0100;
   localparam logic [3:0] ALU_SUBU  = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_LUI   = 4'b1010;
   localparam logic [3:0] ALU_BREAK = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative unsigned shift-add multiplier, one iteration per clock.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start           load operands and begin WIDTH iterations
//   mcand, mplier   unsigned operands (sampled on start)
//   done            high during the cycle whose edge performs the final iteration
//   product         2*WIDTH-bit product register (final one cycle after done)
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] iter;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH:0]   partial;
   logic             busy;

   // Multiplier sits in the low half and shifts out as the upper half accumulates;
   // the extra partial bit keeps the carry of each add.
   assign partial = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand_q} : '0);
   assign done    = busy && (iter == CNT_W'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product <= '0;
         mcand_q <= '0;
         iter    <= '0;
         busy    <= 1'b0;
      end else if (start) begin
         product <= {{WIDTH{1'b0}}, mplier};
         mcand_q <= mcand;
         iter    <= '0;
         busy    <= 1'b1;
      end else if (busy) begin
         product <= {partial, product[WIDTH-1:1]};
         iter    <= iter + CNT_W'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: MIPS execute stage. Single-cycle logic/arith ops plus iterative
// MULT/MULTU with a valid/ready handshake toward issue.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   valid_in, control    op request (accepted when valid_in && ready) and ALU code
//   a, b                 operands
//   ready                can accept a new op
//   valid_out            one-cycle pulse when result/flags update
//   result, zero, overflow   registered result and flags
//   hi, lo               multiply result registers
//   halt                 sticky BREAK indication
//
// state   | meaning
// IDLE    | accepting ops; non-multiply ops complete on the accept edge
// MUL     | shift-add iterations running, ready low
// DONE    | apply sign, load hi/lo/result, pulse valid_out
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEFAULT,
   parameter int CTRL_W = CTRL_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] control,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              ready,
   output logic              valid_out,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              overflow,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              halt
);

   localparam int P_W = 2*WIDTH;

   state_t            state, state_nxt;
   logic              accept, is_mul, mul_start, mul_done, neg;
   logic [WIDTH-1:0]  sum_ab, diff_ab, alu_res, mag_a, mag_b;
   logic              alu_ovf;
   logic [P_W-1:0]    product, prod_fin;

   assign accept  = valid_in && ready;
   assign is_mul  = (control == ALU_MULT) || (control == ALU_MULTU);
   assign sum_ab  = a + b;
   assign diff_ab = a - b;

   // Magnitudes are taken as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
   assign mag_a    = (control == ALU_MULT && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign mag_b    = (control == ALU_MULT && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   assign prod_fin = neg ? (~product + P_W'(1)) : product;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (control)
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_ADD: begin
            alu_res = sum_ab;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_ADDU: alu_res = sum_ab;
         ALU_SUBU: alu_res = diff_ab;
         ALU_SUB: begin
            alu_res = diff_ab;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      ready     = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (valid_in && is_mul) begin
               mul_start = 1'b1;
               state_nxt = ST_MUL;
            end
         end
         ST_MUL:  if (mul_done) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         halt      <= 1'b0;
         neg       <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (accept && !is_mul) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            valid_out <= 1'b1;
            if (control == ALU_BREAK) halt <= 1'b1;
         end
         if (accept && is_mul)
            neg <= (control == ALU_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
         if (state == ST_DONE) begin
            hi        <= prod_fin[P_W-1:WIDTH];
            lo        <= prod_fin[WIDTH-1:0];
            result    <= prod_fin[WIDTH-1:0];
            zero      <= (prod_fin[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            valid_out <= 1'b1;
         end
      end
   end

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .mcand   (mag_a),
      .mplier  (mag_b),
      .done    (mul_done),
      .product (product)
   );

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [3:0]  control = 4'd0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        ready, valid_out, zero, overflow, halt;
   logic [31:0] result, hi, lo;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        v;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        halt;
   } exp_t;

   exp_t        sb[$];
   int          total = 0, bad = 0, vcount = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic        m_halt = 1'b0;

   alu_mc dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .control(control),
      .a(op_a), .b(op_b), .ready(ready), .valid_out(valid_out),
      .result(result), .zero(zero), .overflow(overflow),
      .hi(hi), .lo(lo), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one op and push the model's expectation.
   task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      logic signed [63:0] sx, sy, sp;
      logic [63:0] up;
      e.res = '0; e.v = 1'b0;
      case (c)
         ALU_AND:  e.res = x & y;
         ALU_OR:   e.res = x | y;
         ALU_XOR:  e.res = x ^ y;
         ALU_ADD:  begin e.res = x + y; e.v = (x[31] == y[31]) && (e.res[31] != x[31]); end
         ALU_ADDU: e.res = x + y;
         ALU_SUBU: e.res = x - y;
         ALU_SUB:  begin e.res = x - y; e.v = (x[31] != y[31]) && (e.res[31] != x[31]); end
         ALU_SLT:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_LUI:  e.res = {y[15:0], 16'h0000};
         ALU_MULT: begin
            sx = {{32{x[31]}}, x}; sy = {{32{y[31]}}, y}; sp = sx * sy;
            m_hi = sp[63:32]; m_lo = sp[31:0]; e.res = sp[31:0];
         end
         ALU_MULTU: begin
            up = {32'd0, x} * {32'd0, y};
            m_hi = up[63:32]; m_lo = up[31:0]; e.res = up[31:0];
         end
         ALU_BREAK: m_halt = 1'b1;
         default:  e.res = '0;
      endcase
      e.z = (e.res == 32'd0);
      e.hi = m_hi; e.lo = m_lo; e.halt = m_halt;
      sb.push_back(e);
      valid_in = 1'b1; control = c; op_a = x; op_b = y;
   endtask

   task automatic run_mul(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output int low);
      issue(c, x, y);
      @(negedge clk);
      valid_in = 1'b0;
      cyc = 1; low = 0;
      while (valid_out !== 1'b1 && cyc < 100) begin
         if (ready === 1'b0) low++;
         @(negedge clk);
         cyc++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && valid_out === 1'b1) begin
         exp_t e;
         vcount++;
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_valid_out observed=1 expected=0");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_result", result, e.res);
            chk("sb_zero", zero, e.z);
            chk("sb_overflow", overflow, e.v);
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            chk("sb_halt", halt, e.halt);
         end
      end
   end

   initial begin
      int cyc, low, v0;

      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_halt", halt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD overflow, then ADDU with same operands
      issue(ALU_ADD, 32'h7FFFFFFF, 32'd1);
      @(negedge clk);
      chk("add_vo", valid_out, 1);
      chk("add_res", result, 32'h80000000);
      chk("add_ovf", overflow, 1);
      issue(ALU_ADDU, 32'h7FFFFFFF, 32'd1);
      @(negedge clk);
      chk("addu_vo", valid_out, 1);
      chk("addu_ovf", overflow, 0);
      valid_in = 1'b0;
      @(negedge clk);
      chk("idle_vo", valid_out, 0);
      chk("hold_res", result, 32'h80000000);

      // SUB -> zero, SLT back-to-back
      issue(ALU_SUB, 32'd5, 32'd5);
      @(negedge clk);
      chk("sub_vo", valid_out, 1);
      chk("sub_zero", zero, 1);
      issue(ALU_SLT, 32'hFFFFFFFF, 32'd1);
      @(negedge clk);
      chk("slt_vo", valid_out, 1);
      chk("slt_res", result, 1);
      issue(ALU_SUB, 32'h80000000, 32'd1);
      @(negedge clk);
      chk("sub_ovf", overflow, 1);
      issue(ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
      @(negedge clk);
      issue(ALU_SUBU, 32'd0, 32'd1);
      @(negedge clk);
      chk("subu_ovf", overflow, 0);
      valid_in = 1'b0;
      @(negedge clk);

      // MULT -3 * 7: latency and ready-low window
      run_mul(ALU_MULT, 32'hFFFFFFFD, 32'd7, cyc, low);
      chk("mult_latency", cyc, 34);
      chk("mult_ready_low", low, 33);
      chk("mult_ready_back", ready, 1);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFEB);
      @(negedge clk);
      chk("mult_vo_pulse", valid_out, 0);

      // MULTU max * max with an ignored request mid-multiply
      v0 = vcount;
      issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(negedge clk);
      valid_in = 1'b0;
      for (int i = 1; i < 45; i++) begin
         if (i == 5) begin valid_in = 1'b1; control = ALU_ADD; op_a = 32'd1; op_b = 32'd1; end
         if (i == 8) valid_in = 1'b0;
         @(negedge clk);
      end
      chk("multu_one_vo", vcount - v0, 1);
      chk("multu_hi", hi, 32'hFFFFFFFE);
      chk("multu_lo", lo, 32'd1);

      // MULT -2^31 * -1
      run_mul(ALU_MULT, 32'h80000000, 32'hFFFFFFFF, cyc, low);
      chk("mult_min_latency", cyc, 34);
      chk("mult_min_hi", hi, 32'd0);
      chk("mult_min_lo", lo, 32'h80000000);
      @(negedge clk);

      // LUI, BREAK, then AND keeps halt
      issue(ALU_LUI, 32'hDEAD0000, 32'h00001234);
      @(negedge clk);
      chk("lui_res", result, 32'h12340000);
      issue(ALU_BREAK, 32'd3, 32'd4);
      @(negedge clk);
      chk("break_halt", halt, 1);
      chk("break_res", result, 0);
      issue(ALU_AND, 32'hFF00FF00, 32'h0FF00FF0);
      @(negedge clk);
      chk("and_res", result, 32'h0F000F00);
      chk("halt_sticky", halt, 1);
      issue(4'b1100, 32'd9, 32'd9);
      @(negedge clk);
      chk("undef_res", result, 0);
      valid_in = 1'b0;
      @(negedge clk);

      // Reset during cycle 10 of a MULT
      issue(ALU_MULT, 32'd12345, 32'd678);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", ready, 1);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_result", result, 0);
      chk("midrst_halt", halt, 0);
      chk("midrst_vo", valid_out, 0);
      sb.delete();
      m_hi = '0; m_lo = '0; m_halt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      v0 = vcount;
      repeat (40) @(negedge clk);
      chk("midrst_no_vo", vcount - v0, 0);

      issue(ALU_OR, 32'h00F0, 32'h0F00);
      @(negedge clk);
      chk("post_rst_or", result, 32'h0FF0);
      valid_in = 1'b0;
      repeat (2) @(negedge clk);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
